// File: rtl/sr_crypto_pkg.sv
// sr_crypto_pkg: shared definitions for the scalar crypto unit.
//   - operation codes: the SHA-256 sigma/sum group (0..3) and the AES32 group (4..7)
//   - FSM state encoding, which is also exported on the debug port
//   - GF(2^8) arithmetic over polynomial 0x11B, and 32-bit rotate helpers
package sr_crypto_pkg;

  localparam logic [2:0] CRY_SIG0 = 3'd0;
  localparam logic [2:0] CRY_SIG1 = 3'd1;
  localparam logic [2:0] CRY_SUM0 = 3'd2;
  localparam logic [2:0] CRY_SUM1 = 3'd3;
  localparam logic [2:0] CRY_ESI  = 3'd4;
  localparam logic [2:0] CRY_ESMI = 3'd5;
  localparam logic [2:0] CRY_DSI  = 3'd6;
  localparam logic [2:0] CRY_DSMI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SBOX = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Multiply by x (0x02) modulo 0x11B.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Shift-and-add GF(2^8) multiply.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

  // A shift by 32 yields zero, so a rotate amount of 0 returns x unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] sh);
    return (x >> sh) | (x << (6'd32 - {1'b0, sh}));
  endfunction

  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
    return (x << sh) | (x >> (6'd32 - {1'b0, sh}));
  endfunction

endpackage

// File: rtl/sr_crypto_if.sv
// sr_crypto_if: issue/result bundle between the crypto sequencer and sr_crypto_unit.
//   master (sequencer): drives start, op, bs, rs1, rs2; observes busy, done, result
//   slave  (unit)     : the reverse
// Handshake: an issue transfers on a rising clk edge where start=1 and busy=0;
// op/bs/rs1/rs2 are sampled only on that edge, so they may change freely afterwards.
// start while busy=1 is dropped, not queued. done is a one-cycle pulse and result
// is valid in that cycle, holding its value until the next done.
interface sr_crypto_if;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  bs;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (output start, op, bs, rs1, rs2, input busy, done, result);
  modport slave  (input start, op, bs, rs1, rs2, output busy, done, result);
endinterface

// File: rtl/sr_aes_sbox.sv
// sr_aes_sbox: combinational AES S-box, forward or inverse, without lookup tables.
//   in  [7:0] byte to substitute
//   inv       0 = forward S-box, 1 = inverse S-box
//   out [7:0] substituted byte
// Forward: GF(2^8) inverse followed by the affine transform.
// Inverse: inverse affine transform followed by the GF(2^8) inverse.
module sr_aes_sbox
  import sr_crypto_pkg::*;
(
  input  logic [7:0] in,
  input  logic       inv,
  output logic [7:0] out
);

  function automatic logic [7:0] rol8(input logic [7:0] x, input logic [2:0] n);
    return (x << n) | (x >> (4'd8 - {1'b0, n}));
  endfunction

  // a^254 via square-and-multiply: 254 = 2+4+...+128. Zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] pre;
  logic [7:0] pinv;

  always_comb begin
    pre  = inv ? (rol8(in, 3'd1) ^ rol8(in, 3'd3) ^ rol8(in, 3'd6) ^ 8'h05) : in;
    pinv = gf_inv(pre);
    out  = inv ? pinv
               : (pinv ^ rol8(pinv, 3'd1) ^ rol8(pinv, 3'd2) ^ rol8(pinv, 3'd3)
                  ^ rol8(pinv, 3'd4) ^ 8'h63);
  end

endmodule

// File: rtl/sr_crypto_unit.sv
// sr_crypto_unit: multi-cycle execution unit for scalar SHA-256 sigma/sum and
// AES32 middle/final-round instructions.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sr_crypto_if.slave (start/op/bs/rs1/rs2 in, busy/done/result out)
//   dbg_state  : current FSM state
// SHA ops finish on the accept edge (done one cycle later). AES ops go through
// SBOX (register the substituted byte) and MIX (MixColumn + rotate into result).
module sr_crypto_unit
  import sr_crypto_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  sr_crypto_if.slave  bus,
  output state_t      dbg_state
);

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        busy;
  logic        done;

  logic [2:0]  op_q;
  logic [1:0]  bs_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [7:0]  x_q;
  logic [31:0] result_q;

  logic [31:0] sha_res;
  logic [7:0]  sbox_in;
  logic [7:0]  sbox_out;
  logic [31:0] mix_word;
  logic [31:0] aes_res;

  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_next = bus.op[2] ? ST_SBOX : ST_DONE;
      end
      ST_SBOX: begin
        busy       = 1'b1;
        state_next = ST_MIX;
      end
      ST_MIX: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (bus.start) state_next = bus.op[2] ? ST_SBOX : ST_DONE;
        else           state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // SHA result is formed straight from the issuing operand and registered on accept.
  always_comb begin
    sha_res = 32'h0;
    case (bus.op[1:0])
      2'd0: sha_res = ror32(bus.rs1, 5'd7)  ^ ror32(bus.rs1, 5'd18) ^ (bus.rs1 >> 3);
      2'd1: sha_res = ror32(bus.rs1, 5'd17) ^ ror32(bus.rs1, 5'd19) ^ (bus.rs1 >> 10);
      2'd2: sha_res = ror32(bus.rs1, 5'd2)  ^ ror32(bus.rs1, 5'd13) ^ ror32(bus.rs1, 5'd22);
      default: sha_res = ror32(bus.rs1, 5'd6) ^ ror32(bus.rs1, 5'd11) ^ ror32(bus.rs1, 5'd25);
    endcase
  end

  always_comb begin
    case (bs_q)
      2'd0:    sbox_in = rs2_q[7:0];
      2'd1:    sbox_in = rs2_q[15:8];
      2'd2:    sbox_in = rs2_q[23:16];
      default: sbox_in = rs2_q[31:24];
    endcase
  end

  // op[1] selects decrypt (inverse S-box), op[0] selects the MixColumn variants.
  sr_aes_sbox u_sbox (
    .in  (sbox_in),
    .inv (op_q[1]),
    .out (sbox_out)
  );

  always_comb begin
    mix_word = {24'h0, x_q};
    if (op_q[0]) begin
      if (!op_q[1]) mix_word = {gf_mul(8'h03, x_q), x_q, x_q, gf_mul2(x_q)};
      else          mix_word = {gf_mul(8'h0B, x_q), gf_mul(8'h0D, x_q),
                                gf_mul(8'h09, x_q), gf_mul(8'h0E, x_q)};
    end
    aes_res = rs1_q ^ rol32(mix_word, {bs_q, 3'b000});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= 3'd0;
      bs_q     <= 2'd0;
      rs1_q    <= 32'h0;
      rs2_q    <= 32'h0;
      x_q      <= 8'h0;
      result_q <= 32'h0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        bs_q  <= bus.bs;
        rs1_q <= bus.rs1;
        rs2_q <= bus.rs2;
        if (!bus.op[2]) result_q <= sha_res;
      end
      if (state == ST_SBOX) x_q <= sbox_out;
      // MIX is only reachable by an AES op.
      if ((state == ST_MIX) && op_q[2]) result_q <= aes_res;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_sr_crypto_unit.sv
// tb_sr_crypto_unit: directed vector table, multi-cycle corner sequences, a full
// byte sweep and random ops against a table-based GF(2^8)/AES reference model.
module tb_sr_crypto_unit;
  import sr_crypto_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   rst_n = 1'b0;
  state_t dbg_state;

  sr_crypto_if bus();

  sr_crypto_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // GF(2^8) via exp/log tables over generator 3; S-box from the affine bit formula.
  logic [7:0] exp_t[256];
  logic [7:0] log_t[256];
  logic [7:0] fwd_t[256];
  logic [7:0] inv_t[256];

  task automatic build_model();
    logic [7:0] v;
    logic [7:0] g;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    v = 8'h01;
    log_t[0] = 8'h00;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = v;
      log_t[v] = 8'(i);
      v = v ^ ((v << 1) ^ (v[7] ? 8'h1B : 8'h00));
    end
    exp_t[255] = exp_t[0];
    for (int a = 0; a < 256; a++) begin
      g = (a == 0) ? 8'h00 : exp_t[(255 - int'(log_t[a])) % 255];
      for (int i = 0; i < 8; i++)
        s[i] = g[i] ^ g[(i + 4) % 8] ^ g[(i + 5) % 8] ^ g[(i + 6) % 8] ^ g[(i + 7) % 8] ^ c[i];
      fwd_t[a] = s;
      inv_t[s] = 8'(a);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(int'(log_t[a]) + int'(log_t[b])) % 255];
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] model(input logic [2:0] op, input logic [1:0] bs,
                                        input logic [31:0] rs1, input logic [31:0] rs2);
    int          sh;
    logic [7:0]  b;
    logic [7:0]  x;
    logic [31:0] m;
    case (op)
      3'd0: return rotr(rs1, 7)  ^ rotr(rs1, 18) ^ (rs1 >> 3);
      3'd1: return rotr(rs1, 17) ^ rotr(rs1, 19) ^ (rs1 >> 10);
      3'd2: return rotr(rs1, 2)  ^ rotr(rs1, 13) ^ rotr(rs1, 22);
      3'd3: return rotr(rs1, 6)  ^ rotr(rs1, 11) ^ rotr(rs1, 25);
      default: ;
    endcase
    sh = 8 * int'(bs);
    b  = rs2[sh +: 8];
    x  = (op == 3'd6 || op == 3'd7) ? inv_t[b] : fwd_t[b];
    case (op)
      3'd5:    m = {gmul(8'h03, x), x, x, gmul(8'h02, x)};
      3'd7:    m = {gmul(8'h0B, x), gmul(8'h0D, x), gmul(8'h09, x), gmul(8'h0E, x)};
      default: m = {24'h0, x};
    endcase
    if (sh != 0) m = (m << sh) | (m >> (32 - sh));
    return rs1 ^ m;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge; issues one op, scrambles the operands after the accept
  // edge, and waits (bounded) for done, checking busy, latency and result.
  task automatic run_op(input logic [2:0] op, input logic [1:0] bs, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] exp, input string name);
    int lat;
    int want_lat;
    want_lat = op[2] ? 3 : 1;
    exp_q.push_back(exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.bs    = bs;
    bus.rs1   = rs1;
    bus.rs2   = rs2;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.rs1   = $urandom();
    bus.rs2   = $urandom();
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
      check({name, " busy"}, 32'(bus.busy), 32'd1);
    end
    check({name, " latency"}, 32'(lat), 32'(want_lat));
    check({name, " busy at done"}, 32'(bus.busy), 32'd0);
    check({name, " result"}, bus.result, exp_q.pop_front());
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  // ---------------- test ----------------
  initial begin
    logic [2:0]  o;
    logic [1:0]  bsel;
    logic [1:0]  bsel2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] e;
    logic [7:0]  y;
    logic [7:0]  z;

    build_model();
    vt[0] = '{CRY_SIG0, 2'd0, 32'h00000001, 32'h0, 32'h02004000};
    vt[1] = '{CRY_SUM0, 2'd0, 32'h00000001, 32'h0, 32'h40080400};
    vt[2] = '{CRY_SIG1, 2'd0, 32'h00000001, 32'h0, 32'h0000A000};
    vt[3] = '{CRY_SUM1, 2'd0, 32'h00000001, 32'h0, 32'h04200080};
    vt[4] = '{CRY_ESI,  2'd0, 32'h0, 32'h00000000, 32'h00000063};
    vt[5] = '{CRY_ESI,  2'd1, 32'h0, 32'h00005300, 32'h0000ED00};
    vt[6] = '{CRY_ESMI, 2'd0, 32'h0, 32'h00000000, 32'hA56363C6};
    vt[7] = '{CRY_DSMI, 2'd0, 32'h12345678, 32'h00000063, 32'h12345678};
    vt[8] = '{CRY_DSI,  2'd2, 32'h0, 32'h00ED0000, 32'h00530000};

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.bs    = 2'd0;
    bus.rs1   = 32'h0;
    bus.rs2   = 32'h0;

    // reset state
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'h0);
    check("reset state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // directed table
    for (int i = 0; i < 9; i++)
      run_op(vt[i].op, vt[i].bs, vt[i].rs1, vt[i].rs2, vt[i].exp, $sformatf("vec%0d", i));

    // start during SBOX/MIX is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = CRY_ESI; bus.bs = 2'd0; bus.rs1 = 32'h0; bus.rs2 = 32'h0;
    @(posedge clk);
    #1;
    bus.op = CRY_SIG0; bus.rs1 = 32'h00000001;
    @(negedge clk);
    check("ign sbox state", 32'(dbg_state), 32'(ST_SBOX));
    check("ign sbox busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("ign mix state", 32'(dbg_state), 32'(ST_MIX));
    check("ign mix busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    check("ign done", 32'(bus.done), 32'd1);
    check("ign result", bus.result, 32'h00000063);
    @(negedge clk);
    check("ign no extra done", 32'(bus.done), 32'd0);
    check("ign idle busy", 32'(bus.busy), 32'd0);
    check("ign idle state", 32'(dbg_state), 32'(ST_IDLE));
    check("ign result held", bus.result, 32'h00000063);

    // start held in DONE is accepted back-to-back, then a SHA stream at full rate
    bus.start = 1'b1; bus.op = CRY_ESMI; bus.bs = 2'd0; bus.rs1 = 32'h0; bus.rs2 = 32'h0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b aes done", 32'(bus.done), 32'd1);
    check("b2b aes result", bus.result, 32'hA56363C6);
    r1 = $urandom();
    bus.start = 1'b1; bus.op = CRY_SUM1; bus.rs1 = r1;
    exp_q.push_back(model(CRY_SUM1, 2'd0, r1, 32'h0));
    @(negedge clk);
    check("b2b sum1 done", 32'(bus.done), 32'd1);
    check("b2b sum1 result", bus.result, exp_q.pop_front());
    for (int k = 0; k < 4; k++) begin
      o  = 3'($urandom_range(0, 3));
      r1 = $urandom();
      bus.start = 1'b1; bus.op = o; bus.rs1 = r1;
      exp_q.push_back(model(o, 2'd0, r1, 32'h0));
      @(negedge clk);
      check("stream done", 32'(bus.done), 32'd1);
      check("stream result", bus.result, exp_q.pop_front());
    end
    bus.start = 1'b0;
    @(negedge clk);

    // reset during MIX aborts the op
    bus.start = 1'b1; bus.op = CRY_ESMI; bus.bs = 2'd1; bus.rs1 = 32'hDEADBEEF; bus.rs2 = 32'h0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort in mix", 32'(dbg_state), 32'(ST_MIX));
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort result", bus.result, 32'h0);
    check("abort state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort no done", 32'(bus.done), 32'd0);
    end
    run_op(CRY_ESI, 2'd0, 32'h0, 32'h0, 32'h00000063, "post reset esi");

    // all 256 bytes: ESI then DSI of the substituted byte
    for (int b = 0; b < 256; b++) begin
      bsel = 2'($urandom_range(0, 3));
      r1   = $urandom();
      r2   = $urandom();
      r2[8 * int'(bsel) +: 8] = 8'(b);
      e = model(CRY_ESI, bsel, r1, r2);
      run_op(CRY_ESI, bsel, r1, r2, e, "sweep esi");
      e = bus.result ^ r1;
      y = e[8 * int'(bsel) +: 8];
      bsel2 = 2'($urandom_range(0, 3));
      r2 = $urandom();
      r2[8 * int'(bsel2) +: 8] = y;
      run_op(CRY_DSI, bsel2, 32'h0, r2, model(CRY_DSI, bsel2, 32'h0, r2), "sweep dsi");
      e = bus.result;
      z = e[8 * int'(bsel2) +: 8];
      check("sweep inv(fwd(b))", 32'(z), 32'(b));
    end

    // random mix of all ops
    for (int k = 0; k < 200; k++) begin
      o    = 3'($urandom_range(0, 7));
      bsel = 2'($urandom_range(0, 3));
      r1   = $urandom();
      r2   = $urandom();
      run_op(o, bsel, r1, r2, model(o, bsel, r1, r2), $sformatf("rand op%0d", o));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
